// File: rtl/key_stream_gen_if.sv
// Handshake and data bundle for key_stream_gen: run control in, serial key bits
// and the assembled key word out.
interface key_stream_gen_if #(
  parameter int unsigned NBITS = 32
) ();
  logic             start;
  logic [3:0]       seed_a;
  logic [3:0]       seed_b;
  logic             hold;
  logic             abort;
  logic             ready;
  logic             bit_valid;
  logic             bit_out;
  logic [5:0]       bit_idx;
  logic [NBITS-1:0] key;
  logic             done;

  modport master (
    output start, seed_a, seed_b, hold, abort,
    input  ready, bit_valid, bit_out, bit_idx, key, done
  );

  modport slave (
    input  start, seed_a, seed_b, hold, abort,
    output ready, bit_valid, bit_out, bit_idx, key, done
  );
endinterface

// File: rtl/key_stream_gen.sv
// key_stream_gen: reproduces the serial key checker's two-register 4-bit
// additive sequence, streams each key bit with a valid/index strobe and
// publishes the assembled key word with a one-cycle done pulse.
module key_stream_gen #(
  parameter int unsigned NBITS = 32
) (
  input  logic              clock,
  input  logic              reset,
  key_stream_gen_if.slave   bus
);

  localparam logic [5:0] LAST_K = 6'(NBITS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [5:0]       r_k;
  logic             r_first;
  logic [NBITS-1:0] r_acc;
  logic [NBITS-1:0] r_key;
  logic             r_done;

  logic             w_accept;
  logic             w_valid;
  logic             w_step;
  logic             w_last;
  logic [7:0]       w_byte;
  logic             w_bit;
  logic [3:0]       w_sum;
  logic [NBITS-1:0] w_acc_nxt;

  // Sequence datapath: current bit, next sum and accumulator with this bit merged in
  always_comb begin
    w_byte    = {r_b, r_a};
    w_bit     = w_byte[r_k[2:0]];
    w_sum     = r_a + r_b + {3'b000, r_first};
    w_last    = (r_k == LAST_K);
    // Accumulator is cleared on accept, so OR-ing the shifted bit equals a bit write
    w_acc_nxt = r_acc | ({{(NBITS-1){1'b0}}, w_bit} << r_k);
  end

  // Next-state and step strobes; abort outranks hold, hold outranks stepping
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_valid     = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_valid = ~bus.hold;
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (!bus.hold) begin
          w_step = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequence registers, accumulator, published key and done pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_first <= 1'b0;
      r_acc   <= '0;
      r_key   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= bus.seed_a;
        r_b     <= bus.seed_b;
        r_k     <= '0;
        r_acc   <= '0;
        r_first <= 1'b1;
      end else if (w_step) begin
        r_acc   <= w_acc_nxt;
        r_first <= 1'b0;
        if (r_k[2]) begin
          r_a <= w_sum;
        end else begin
          r_b <= w_sum;
        end
        if (w_last) begin
          r_key  <= w_acc_nxt;
          r_done <= 1'b1;
          r_k    <= '0;
        end else begin
          r_k <= r_k + 6'd1;
        end
      end
    end
  end

  // Outputs; serial bit and index are forced to zero whenever no bit is valid
  always_comb begin
    bus.ready     = (r_state == S_IDLE);
    bus.bit_valid = w_valid;
    bus.bit_out   = w_valid & w_bit;
    bus.bit_idx   = w_valid ? r_k : 6'd0;
    bus.key       = r_key;
    bus.done      = r_done;
  end

endmodule

// File: tb/tb_key_stream_gen.sv
// Directed bench for key_stream_gen: zero-seed reference key, hold, abort,
// hold+abort, nonzero seeds, back-to-back runs and mid-run async reset.
module tb_key_stream_gen;

  localparam int unsigned NBITS = 32;
  localparam logic [31:0] ZKEY  = 32'h1C181410;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  key_stream_gen_if #(.NBITS(NBITS)) bus ();

  key_stream_gen #(.NBITS(NBITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference key for arbitrary seeds, stepping the additive sequence directly
  function automatic logic [31:0] model_key(input logic [3:0] a0, input logic [3:0] b0);
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  s;
    logic        f;
    logic [7:0]  byt;
    logic [31:0] kk;
    a  = a0;
    b  = b0;
    f  = 1'b1;
    kk = '0;
    for (int i = 0; i < 32; i++) begin
      byt   = {b, a};
      kk[i] = byt[i % 8];
      s     = a + b + {3'b000, f};
      if ((i & 4) != 0) a = s;
      else              b = s;
      f = 1'b0;
    end
    return kk;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},     bus.ready,     1'b1);
    check({tag, "_bit_valid"}, bus.bit_valid, 1'b0);
    check({tag, "_bit_out"},   bus.bit_out,   1'b0);
    check({tag, "_bit_idx"},   bus.bit_idx,   6'd0);
    check({tag, "_key"},       bus.key,       '0);
    check({tag, "_done"},      bus.done,      1'b0);
  endtask

  // Called at the sampling phase of an idle (or done) cycle; the next edge accepts.
  // A second start with different seeds is pulsed at k=3 and must be ignored.
  task automatic run_gen(input logic [3:0] sa, input logic [3:0] sb,
                         input logic [31:0] exp_key, input logic [31:0] prev_key,
                         input int hold_at, input int hold_len, input int abort_at,
                         input bit chain);
    int k       = 0;
    int held    = 0;
    int cyc     = 0;
    bit fin     = 1'b0;
    bit aborted = 1'b0;
    bus.seed_a = sa;
    bus.seed_b = sb;
    bus.start  = 1'b1;
    for (int c = 1; c <= 120 && !fin; c++) begin
      @(posedge clock); #1;
      cyc        = c;
      bus.start  = (k == 3);
      bus.seed_a = (k == 3) ? ~sa : sa;
      bus.seed_b = (k == 3) ? ~sb : sb;
      bus.hold   = (k == hold_at) && (held < hold_len);
      bus.abort  = (k == abort_at);
      #1;
      check("run_ready", bus.ready, 1'b0);
      check("run_done",  bus.done,  1'b0);
      check("run_valid", bus.bit_valid, !bus.hold);
      if (!bus.hold) begin
        check("run_idx", bus.bit_idx, 6'(k));
        check("run_bit", bus.bit_out, exp_key[k]);
      end else begin
        check("hold_bit_zero", bus.bit_out, 1'b0);
      end
      if (bus.abort) begin
        aborted = 1'b1;
        fin     = 1'b1;
      end else if (bus.hold) begin
        held++;
      end else if (k == NBITS - 1) begin
        fin = 1'b1;
      end else begin
        k++;
      end
    end
    if (!fin) check("run_timeout", 1'b0, 1'b1);
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    bus.seed_a = sa;
    bus.seed_b = sb;
    #1;
    check("post_ready", bus.ready, 1'b1);
    check("post_valid", bus.bit_valid, 1'b0);
    if (aborted) begin
      check("abort_no_done", bus.done, 1'b0);
      check("abort_key",     bus.key,  prev_key);
    end else begin
      check("done_pulse",   bus.done, 1'b1);
      check("done_key",     bus.key,  exp_key);
      check("done_latency", cyc + 1,  NBITS + 1 + hold_len);
    end
    if (!chain) begin
      @(posedge clock); #2;
      check("idle_done_low", bus.done, 1'b0);
      check("idle_ready",    bus.ready, 1'b1);
      check("idle_key",      bus.key, aborted ? prev_key : exp_key);
    end
  endtask

  logic [31:0] kk96;

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.seed_a = '0;
    bus.seed_b = '0;
    bus.hold   = 1'b0;
    bus.abort  = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("rst");

    // Zero seeds, no holds
    run_gen(4'h0, 4'h0, ZKEY, 32'h0, -1, 0, -1, 1'b0);
    // Hold for 3 cycles at k=10
    run_gen(4'h0, 4'h0, ZKEY, ZKEY, 10, 3, -1, 1'b0);
    // Abort at k=20 keeps the previous key
    run_gen(4'h0, 4'h0, ZKEY, ZKEY, -1, 0, 20, 1'b0);
    // Hold and abort together abort the run
    run_gen(4'h0, 4'h0, ZKEY, ZKEY, 5, 2, 5, 1'b0);

    // Nonzero seeds chained back-to-back with two zero-seed runs
    kk96 = model_key(4'h9, 4'h6);
    run_gen(4'h9, 4'h6, kk96, ZKEY, -1, 0, -1, 1'b1);
    run_gen(4'h0, 4'h0, ZKEY, kk96, -1, 0, -1, 1'b1);
    run_gen(4'h0, 4'h0, ZKEY, ZKEY, -1, 0, -1, 1'b0);

    // Async reset at k=7
    bus.seed_a = '0;
    bus.seed_b = '0;
    bus.start  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
      #1;
    end
    check("pre_reset_idx", bus.bit_idx, 6'd7);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst_rel");
    run_gen(4'h0, 4'h0, ZKEY, 32'h0, -1, 0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
